// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (read-only) and
// data load/store. One transaction in flight; data port wins ties unless
// fetch has already lost MAX_STREAK consecutive arbitrations.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t        state, state_next;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic          any_req;
  logic          if_wins;
  logic          resp_done;

  // Arbitration decision and completion detection
  always_comb begin
    any_req   = if_req | d_req;
    if_wins   = if_req && (!d_req || (streak == STREAK_MAX));
    resp_done = ((state == REQ) && mem_gnt && mem_rvalid) ||
                ((state == RESP) && mem_rvalid);
    if_gnt    = (state == REQ) && mem_gnt && (owner == OWN_IF);
    d_gnt     = (state == REQ) && mem_gnt && (owner == OWN_D);
  end

  // Next-state logic; a response coinciding with the grant skips RESP
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = REQ;
      REQ:     if (mem_gnt) state_next = mem_rvalid ? IDLE : RESP;
      RESP:    if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Request latching, streak tracking and response delivery
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owner     <= OWN_IF;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if ((state == IDLE) && any_req) begin
        mem_req <= 1'b1;
        if (if_wins) begin
          owner     <= OWN_IF;
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_be    <= '1;
          streak    <= '0;
        end else begin
          owner     <= OWN_D;
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_be    <= d_be;
          if (!if_req)                  streak <= '0;
          else if (streak != STREAK_MAX) streak <= streak + SW'(1);
        end
      end
      if ((state == REQ) && mem_gnt) mem_req <= 1'b0;
      if (resp_done) begin
        if (owner == OWN_IF) begin
          if_rdata  <= mem_rdata;
          if_rvalid <= 1'b1;
        end else begin
          d_rdata   <= mem_rdata;
          d_rvalid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter; the bench plays both
// requesters and the memory, predicting winners from the arbitration rules.
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  // Reference state: fetch losses in a row, last delivered data per port
  int          streak;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   0);
    chk({tag, "_mem_we"},    32'(mem_we),    0);
    chk({tag, "_mem_addr"},  mem_addr,       0);
    chk({tag, "_mem_wdata"}, mem_wdata,      0);
    chk({tag, "_mem_be"},    32'(mem_be),    0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, "_d_rvalid"},  32'(d_rvalid),  0);
    chk({tag, "_if_rdata"},  if_rdata,       0);
    chk({tag, "_d_rdata"},   d_rdata,        0);
    chk({tag, "_if_gnt"},    32'(if_gnt),    0);
    chk({tag, "_d_gnt"},     32'(d_gnt),     0);
  endtask

  task automatic do_reset();
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    n_rst = 0;
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1;
    streak = 0; exp_if_rdata = 0; exp_d_rdata = 0;
  endtask

  // Called at a negedge with DUT idle and at least one request pending.
  // Returns at the negedge of the rvalid pulse cycle (DUT idle again).
  task automatic run_txn(input int gdelay, input int rdelay, input bit same,
                         input logic [31:0] rd, output logic obs_if);
    bit          w_if;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    w_if = if_req && (!d_req || streak == MAXS);
    if (w_if) begin
      e_we = 0; e_addr = if_addr; e_wdata = 0; e_be = 4'hF; streak = 0;
    end else begin
      e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
      streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
    end
    @(negedge clk);
    chk("rvalid_clear_if", 32'(if_rvalid), 0);
    chk("rvalid_clear_d",  32'(d_rvalid),  0);
    for (int k = 0; k <= gdelay; k++) begin
      chk("req_held", 32'(mem_req), 1);
      chk("req_addr", mem_addr, e_addr);
      chk("req_we",   32'(mem_we), 32'(e_we));
      chk("req_be",   32'(mem_be), 32'(e_be));
      if (!w_if) chk("req_wdata", mem_wdata, e_wdata);
      if (k < gdelay) begin
        mem_gnt = 0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        chk("no_gnt_wait_if", 32'(if_gnt), 0);
        chk("no_gnt_wait_d",  32'(d_gnt),  0);
        @(negedge clk);
      end
    end
    mem_gnt = 1; mem_rvalid = same; mem_rdata = rd;
    #1;
    obs_if = if_gnt;
    chk("gnt_if", 32'(if_gnt), 32'(w_if));
    chk("gnt_d",  32'(d_gnt),  32'(!w_if));
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 0;
    if (w_if) if_req = 0; else d_req = 0;
    if (!same) begin
      chk("resp_req_low", 32'(mem_req), 0);
      for (int k = 0; k < rdelay; k++) begin
        mem_gnt = 1'($urandom_range(0, 1));
        #1;
        chk("resp_no_gnt_if", 32'(if_gnt), 0);
        chk("resp_no_gnt_d",  32'(d_gnt),  0);
        @(negedge clk);
        chk("resp_no_rv", 32'(if_rvalid | d_rvalid), 0);
      end
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = rd;
      #1;
      chk("rv_cycle_gnt", 32'(if_gnt | d_gnt), 0);
      @(negedge clk);
      mem_rvalid = 0;
    end
    if (w_if) exp_if_rdata = rd; else exp_d_rdata = rd;
    chk("pulse_if", 32'(if_rvalid), 32'(w_if));
    chk("pulse_d",  32'(d_rvalid),  32'(!w_if));
    chk("rdata_if", if_rdata, exp_if_rdata);
    chk("rdata_d",  d_rdata,  exp_d_rdata);
  endtask

  // Idle cycles with stray memory handshakes that must be ignored
  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      chk("idle_gnt", 32'(if_gnt | d_gnt), 0);
      @(negedge clk);
      chk("idle_req", 32'(mem_req), 0);
      chk("idle_rv", 32'(if_rvalid | d_rvalid), 0);
      chk("idle_rdata_if", if_rdata, exp_if_rdata);
      chk("idle_rdata_d",  d_rdata,  exp_d_rdata);
    end
    mem_gnt = 0; mem_rvalid = 0;
  endtask

  logic obs;

  initial begin
    // 1: single fetch, fastest memory
    do_reset();
    if_req = 1; if_addr = 32'h100;
    run_txn(0, 0, 0, 32'h00500093, obs);

    // 2: store with partial byte enables
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    run_txn(0, 1, 0, 32'h0, obs);

    // 3: simultaneous requests, data first then fetch
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    run_txn(0, 0, 0, 32'h11112222, obs);
    chk("t3_first_is_d", 32'(obs), 0);
    run_txn(1, 0, 0, 32'h33334444, obs);
    chk("t3_second_is_if", 32'(obs), 1);

    // 4: both held continuously: D,D,D,D,IF,D,D,D,D,IF
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (!if_req) begin if_req = 1; if_addr = 32'h400 + 32'(i * 4); end
      if (!d_req)  begin d_req = 1; d_we = 0; d_addr = 32'h800 + 32'(i * 4); end
      run_txn(0, 0, 0, $urandom, obs);
      chk("t4_seq", 32'(obs), 32'(i == 4 || i == 9));
    end
    if_req = 0; d_req = 0;

    // 5: delayed grant, then grant and response together
    d_req = 1; d_we = 1; d_addr = 32'hA00; d_wdata = 32'h12345678; d_be = 4'hF;
    run_txn(3, 0, 0, 32'h0, obs);
    if_req = 1; if_addr = 32'hB00;
    run_txn(0, 0, 1, 32'hCAFEF00D, obs);

    // 6: reset during RESP; late response must be ignored
    idle_check(1);
    if_req = 1; if_addr = 32'hC00;
    @(negedge clk);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; if_req = 0;
    n_rst = 0;
    #1;
    chk_all_zero("t6_rst");
    @(negedge clk);
    n_rst = 1;
    streak = 0; exp_if_rdata = 0; exp_d_rdata = 0;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    mem_rvalid = 0;
    chk_all_zero("t6_late");
    if_req = 1; if_addr = 32'hD00;
    run_txn(0, 0, 0, 32'h0badc0de, obs);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom);
      end
      if (!if_req && !d_req) begin
        idle_check(int'($urandom_range(1, 2)));
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              $urandom_range(0, 3) == 0, $urandom, obs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port memory between the instruction-fetch port (read-only) and the data load/store port of the RV32I core.
- Used when instruction and data memory are merged into one unified memory.
- Sits between the fetch/memory stages and the memory macro.
- Allows one outstanding transaction at a time; data port has priority, with an anti-starvation limit for fetch.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
MAX_STREAK, 4, max consecutive data-port wins while fetch is waiting before fetch is forced to win

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch request accepted by memory
if_rvalid  output  1  fetch read data valid (1-cycle pulse)
if_rdata  output  DATA_W  fetch read data
d_req  input  1  data request; held with fields until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_be  input  DATA_W/8  store byte enables
d_gnt  output  1  data request accepted by memory
d_rvalid  output  1  load data valid / store ack (1-cycle pulse)
d_rdata  output  DATA_W  load data
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_gnt  input  1  memory accepted request this cycle
mem_rvalid  input  1  memory response (read data or write ack)
mem_rdata  input  DATA_W  memory read data

Behaviour:
- Reset:
  - state=IDLE, owner=IF, streak=0.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be = 0.
  - if_rvalid, d_rvalid = 0; if_rdata, d_rdata = 0.
  - Reset mid-transaction abandons it; a late mem_rvalid is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any request is pending: pick a winner, latch owner plus addr/we/wdata/be into mem_* registers, set mem_req=1, go to REQ next cycle.
  - Fetch winner drives mem_we=0 and mem_be=all ones.
  - No request: stay in IDLE, mem_req=0.
- Arbitration order:
  - If only one request is pending, it wins.
  - If both are pending and streak==MAX_STREAK, IF wins.
  - If both are pending otherwise, D wins.
- streak update:
  - Incremented when D wins while if_req=1.
  - Cleared when IF wins, or when if_req=0 at arbitration.
  - Saturates at MAX_STREAK.
- REQ:
  - mem_req and mem_* fields are held stable.
  - On mem_gnt: owner's gnt (if_gnt or d_gnt) = 1 combinationally this cycle; mem_req drops next cycle; go to RESP.
  - If mem_rvalid arrives in the same cycle as mem_gnt: treat as completion and go directly to IDLE.
  - gnt is never asserted outside REQ, and never to the non-owner.
- RESP:
  - Wait for mem_rvalid. On it: latch mem_rdata into the owner's rdata, pulse the owner's rvalid next cycle, go to IDLE.
- Latency: request to memory 1 cycle after request seen in IDLE; rvalid to requester 1 cycle after mem_rvalid.
- Minimum transaction: 3 cycles when mem_gnt is immediate and mem_rvalid arrives the following cycle.
- Back-to-back: new arbitration occurs in the IDLE cycle that coincides with the previous rvalid pulse.
- rdata registers hold their value until the next response for that port.
- Stray inputs:
  - mem_rvalid in IDLE, or in REQ without mem_gnt: ignored.
  - mem_gnt outside REQ: ignored.
- Requester drops req before gnt (protocol violation): the latched transaction still completes and its response is still delivered.
- Store response: d_rvalid pulses as the ack; d_rdata takes mem_rdata (don't-care for stores).

Test Plan:
1. Single fetch, if_addr=0x100, mem_gnt immediate, mem_rvalid next cycle with 0x00500093 -> mem_req at cycle 1, if_gnt at cycle 1, if_rvalid=1 and if_rdata=0x00500093 at cycle 3; d_gnt and d_rvalid stay 0.
2. Store, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 and fields match exactly while in REQ; d_rvalid pulses once after mem_rvalid.
3. if_req and d_req both asserted in the same cycle -> D wins first, IF wins second; each rvalid goes only to its owner.
4. d_req held continuously with if_req always high, MAX_STREAK=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
5. mem_gnt delayed 3 cycles -> mem_req and mem_addr stable for all 3 cycles, gnt a single pulse; mem_gnt and mem_rvalid in the same cycle -> FSM returns to IDLE and rvalid pulses next cycle.
6. n_rst asserted in RESP, then mem_rvalid arrives after reset release -> all outputs 0, state IDLE, no rvalid pulse; the next fetch completes normally.
